// File: rtl/spm_mult_param.sv
// Parametrised serial-parallel multiplier: one multiplier bit per cycle, WIDTH cycles start-to-done.
// Signed/unsigned per operation; back-to-back start accepted in DONE; P held until next result.
module spm_mult_param #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     MP,
   input  logic [WIDTH-1:0]     MC,
   output logic [2*WIDTH-1:0]   P,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               r_state;
   state_t               w_next;
   logic [WIDTH-1:0]     r_mp;
   logic [WIDTH-1:0]     r_mc;
   logic                 r_sgn;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_p;

   logic                 w_accept;
   logic                 w_last;
   logic [2*WIDTH-1:0]   w_mc_ext;
   logic [2*WIDTH-1:0]   w_pp_sh;
   logic [2*WIDTH-1:0]   w_acc_nxt;

   assign w_accept = start && (r_state != S_RUN);
   assign w_last   = (r_cnt == CW'(WIDTH-1));
   assign w_mc_ext = r_sgn ? {{WIDTH{r_mc[WIDTH-1]}}, r_mc} : {{WIDTH{1'b0}}, r_mc};
   assign w_pp_sh  = (r_mp[r_cnt] ? w_mc_ext : '0) << r_cnt;
   // Signed MSB carries weight -2^(WIDTH-1), so its partial product is subtracted.
   assign w_acc_nxt = (r_sgn && w_last) ? (r_acc - w_pp_sh) : (r_acc + w_pp_sh);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = start ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == S_RUN);
      done = (r_state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mp  <= '0;
         r_mc  <= '0;
         r_sgn <= 1'b0;
         r_cnt <= '0;
         r_acc <= '0;
         r_p   <= '0;
      end else if (w_accept) begin
         r_mp  <= MP;
         r_mc  <= MC;
         r_sgn <= is_signed;
         r_cnt <= '0;
         r_acc <= '0;
      end else if (r_state == S_RUN) begin
         r_acc <= w_acc_nxt;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) r_p <= w_acc_nxt;
      end
   end

   assign P = r_p;

endmodule

// File: doc/spm_mult_param.md
Name: spm_mult_param

Overview:
Parametrised serial-parallel multiplier. It is the successor to the fixed 32-bit signed SPM.
- Operand width is set by a parameter.
- Signed or unsigned mode is selected per operation.
- Adds a busy flag, a defined done pulse, back-to-back start acceptance and a held result.
- Sits beside the datapath as a multi-cycle arithmetic unit, driven by a start/done handshake from the controlling FSM.

Parameters:
WIDTH, 32, operand width in bits (legal range 4..64); product width is 2*WIDTH.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a new multiplication; sampled on the rising edge of clk.
is_signed  input  1  1 = two's-complement operands; 0 = unsigned; sampled with start.
MP  input  WIDTH  multiplier operand; sampled with start.
MC  input  WIDTH  multiplicand operand; sampled with start.
P  output  2*WIDTH  product; valid while done=1, then held until the next accepted start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when P becomes valid.

Behaviour:
- Reset:
  - synchronous; rst=1 at a rising edge forces state IDLE.
  - P=0, busy=0, done=0; internal counter and accumulator cleared.
  - rst has priority over start in the same cycle.
- States:
  - IDLE: wait for start.
  - RUN: shift-add, one multiplier bit per cycle.
  - DONE: result presented.
- IDLE, start=1 at edge k:
  - latch MP, MC and is_signed.
  - clear the accumulator and bit counter.
  - go to RUN; busy=1 from edge k.
- RUN:
  - each cycle processes MP bit [cnt], LSB first.
  - Partial product is MC when the bit is set, else 0, sign-extended to 2*WIDTH when signed.
  - The partial product is shifted left by cnt and added to the accumulator.
  - Signed mode, cnt = WIDTH-1: the partial product is subtracted, not added (two's-complement MSB weight -2^(WIDTH-1)).
  - Exactly WIDTH RUN cycles. At edge k+WIDTH: go to DONE, register P = accumulator result, busy=0, done=1.
- DONE:
  - lasts one cycle; done=1 for exactly one cycle, at edges k+WIDTH..k+WIDTH+1.
  - Next edge with start=0: go to IDLE, done=0, P held.
  - Next edge with start=1: accepted like IDLE (back-to-back; new latency counts from this edge); P held until the new result is written.
- Latency: start edge to done edge = WIDTH cycles. Throughput = one result per WIDTH+1 cycles.
- Width rules:
  - Product is always full 2*WIDTH; no truncation or overflow possible.
  - Unsigned: P = MP*MC, zero-extended.
  - Signed: P = two's-complement 2*WIDTH-bit product.
- start during RUN is ignored; latched operands and timing are unaffected. MP, MC and is_signed may change freely after acceptance.
- Reset mid-RUN: aborts to IDLE; no done is produced for the aborted operation; P=0.
- Zero operands still take the full WIDTH cycles (no early termination).

Test Plan:
- WIDTH=32, signed, 1..9 x 1..9 sweep, start per pair -> each P equals i*j; done occurs exactly 32 cycles after start; busy=1 throughout RUN.
- WIDTH=32, signed corners:
  - MP=-1, MC=-1 -> P=0x0000000000000001.
  - MP=MC=0x80000000 -> P=0x4000000000000000.
  - MP=7, MC=-3 -> P=0xFFFFFFFFFFFFFFEB.
- WIDTH=32, unsigned: MP=MC=0xFFFFFFFF -> P=0xFFFFFFFE00000001. The same operands with is_signed=1 -> P=0x0000000000000001.
- WIDTH=8, signed: MP=0x80, MC=0x7F -> P=0xC080. start is pulsed again at cycle 3 of RUN with other operands -> ignored; done arrives at cycle 8 with the original result.
- Back-to-back:
  - start held high across DONE with 5x6 then 3x4 -> done pulses at cycles 32 and 65.
  - P=30 from cycle 32 through 64; P=12 from cycle 65.
- Reset mid-op: rst=1 for one cycle at RUN cycle 10 -> P=0, busy=0, no done. A subsequent start with 2x3 gives P=6 after 32 cycles.
